gal_fuse_sop: RTL and testbench

Runtime-loadable GAL output cell. It consumes the serial fuse stream that the GAL flow writes: a product-term table followed by the macrocell mode bits. It then evaluates the loaded sum-of-products on its inputs and drives the result through a combinational or registered, optionally inverted, output stage. It sits downstream of a fuse-stream source (a JEDEC player or test bench) and gives an emulated GAL device one reconfigurable output pin.

---
 rtl/gal_fuse_sop_pkg.sv | 18 +
 rtl/gal_fuse_sop_if.sv | 24 ++
 rtl/gal_fuse_sop_eval.sv | 27 ++
 rtl/gal_fuse_sop.sv | 103 ++++++++++
 tb/tb_gal_fuse_sop.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gal_fuse_sop_pkg.sv
// Shared types for the fuse-loaded GAL output cells: loader states,
// configuration bit count and the table index helper.
package gal_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        ACTIVE,
        FAULT
    } state_t;

    localparam int CFG_BITS = 2;

    function automatic int fuse_idx(int i, int j, int pol, int width = 8);
        return 2 * width * i + 2 * j + pol;
    endfunction

endpackage

// File: rtl/gal_fuse_sop_if.sv
// Serial fuse stream from a JEDEC player into a loadable cell.
// Master drives START/FD/FV, the cell answers with FR.
interface gal_fuse_sop_if;

    logic START;
    logic FD;
    logic FV;
    logic FR;

    modport master (
        output START,
        output FD,
        output FV,
        input  FR
    );

    modport slave (
        input  START,
        input  FD,
        input  FV,
        output FR
    );

endinterface

// File: rtl/gal_fuse_sop_eval.sv
// Combinational sum-of-products matcher over a loaded fuse table.
// Per input: pol-0 fuse forbids A=1, pol-1 fuse forbids A=0.
module gal_sop_eval
    import gal_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [2*WIDTH*DEPTH-1:0] tbl,
    output logic                     s
);

    logic [DEPTH-1:0] hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_term
        logic [WIDTH-1:0] ok;
        for (genvar j = 0; j < WIDTH; j++) begin : g_var
            localparam int B0 = fuse_idx(i, j, 0, WIDTH);
            assign ok[j] = !(tbl[B0] && a[j]) && !(tbl[B0+1] && !a[j]);
        end
        assign hit[i] = &ok;
    end

    assign s = |hit;

endmodule

// File: rtl/gal_fuse_sop.sv
// Runtime-loadable GAL output cell: fuse loader, config registers, output stage.
// Build option GAL_FUSE_PARITY_EN appends an even-parity bit to the stream.
module gal_fuse_sop
    import gal_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             C,
    input  logic             R,
    gal_fuse_sop_if.slave    fs,
    input  logic [WIDTH-1:0] A,
    input  logic             E,
    output logic             Y,
    output logic             YOE,
    output logic             LD,
    output logic             ERR
);

    localparam int NT = 2 * WIDTH * DEPTH;
    localparam int N  = NT + CFG_BITS;
`ifdef GAL_FUSE_PARITY_EN
    localparam int LAST = N;
`else
    localparam int LAST = N - 1;
`endif
    localparam int CW = $clog2(N + 1);

    state_t        st;
    logic [CW-1:0] cnt;
    logic [NT-1:0] tbl;
    logic          rg;
    logic          inv;
    logic          q;
    logic          s;
    logic          f;
    logic          take;
`ifdef GAL_FUSE_PARITY_EN
    logic          par;
`endif

    gal_sop_eval #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_eval (
        .a  (A),
        .tbl(tbl),
        .s  (s)
    );

    assign f    = s ^ inv;
    assign take = (st == LOADING) && fs.FV;

    always_ff @(posedge C) begin
        if (R || fs.START) begin
            st  <= R ? EMPTY : LOADING;
            cnt <= '0;
            tbl <= '0;
            rg  <= 1'b0;
            inv <= 1'b0;
            q   <= 1'b0;
`ifdef GAL_FUSE_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            q <= (st == ACTIVE) ? f : 1'b0;
            if (take) begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < NT; k++) begin
                    if (cnt == CW'(k))
                        tbl[k] <= fs.FD;
                end
                if (cnt == CW'(NT))
                    rg <= fs.FD;
                if (cnt == CW'(NT + 1))
                    inv <= fs.FD;
`ifdef GAL_FUSE_PARITY_EN
                par <= par ^ fs.FD;
`endif
                if (cnt == CW'(LAST)) begin
                    cnt <= '0;
`ifdef GAL_FUSE_PARITY_EN
                    // Even parity: all N+1 bits must XOR to zero.
                    st <= (par ^ fs.FD) ? FAULT : ACTIVE;
`else
                    st <= ACTIVE;
`endif
                end
            end
        end
    end

    assign fs.FR = (st == LOADING);
    assign LD    = (st == ACTIVE);
    assign YOE   = LD & E;
    assign Y     = LD ? (rg ? q : f) : 1'b0;
`ifdef GAL_FUSE_PARITY_EN
    assign ERR   = (st == FAULT);
`else
    assign ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_gal_fuse_sop.sv
// Randomized and directed bench for gal_fuse_sop at WIDTH=2, DEPTH=2.
// Honours GAL_FUSE_PARITY_EN when defined for the build.
module tb_gal_fuse_sop;
    import gal_pkg::*;

    localparam int W  = 2;
    localparam int D  = 2;
    localparam int NT = 2 * W * D;
    localparam int N  = NT + CFG_BITS;
`ifdef GAL_FUSE_PARITY_EN
    localparam int NS = N + 1;
`else
    localparam int NS = N;
`endif

    logic         C = 1'b0;
    logic         R = 1'b1;
    logic [W-1:0] A = '0;
    logic         E = 1'b0;
    logic         Y;
    logic         YOE;
    logic         LD;
    logic         ERR;

    gal_fuse_sop_if fs ();

    gal_fuse_sop #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .C  (C),
        .R  (R),
        .fs (fs.slave),
        .A  (A),
        .E  (E),
        .Y  (Y),
        .YOE(YOE),
        .LD (LD),
        .ERR(ERR)
    );

    always #5 C = ~C;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    // Reference model: loaded stream plus activity and register state
    logic [NS-1:0] m_cfg = '0;
    bit            m_act = 0;
    bit            m_q   = 0;

    function automatic bit m_sum(input logic [W-1:0] a);
        for (int i = 0; i < D; i++) begin
            bit ok = 1;
            for (int j = 0; j < W; j++) begin
                // a value v is forbidden when the fuse requiring the other value is set
                int base = 2 * W * i + 2 * j;
                if (m_cfg[base + (a[j] ? 0 : 1)])
                    ok = 0;
            end
            if (ok)
                return 1;
        end
        return 0;
    endfunction

    function automatic bit m_f(input logic [W-1:0] a);
        return m_sum(a) ^ m_cfg[NT+1];
    endfunction

    function automatic bit m_y(input logic [W-1:0] a);
        if (!m_act)
            return 0;
        return m_cfg[NT] ? m_q : m_f(a);
    endfunction

    always @(posedge C) begin
        if (m_act)
            m_q <= m_f(A);
    end

    function automatic logic [NS-1:0] mk(input logic [NT-1:0] t,
                                         input logic rg, input logic inv);
        logic [NS-1:0] v;
        v = '0;
        v[NT-1:0] = t;
        v[NT] = rg;
        v[NT+1] = inv;
`ifdef GAL_FUSE_PARITY_EN
        v[N] = ^v[N-1:0];
`endif
        return v;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_ld"}, LD, m_act);
        chk({tag, "_yoe"}, YOE, m_act & E);
        chk({tag, "_y"}, Y, m_y(A));
    endtask

    task automatic load(input logic [NS-1:0] s, input int gap_at,
                        input int gap_len, input bit exp_ok);
        m_act = 0;
        m_q   = 0;
        fs.START = 1'b1;
        fs.FV = 1'b1;
        fs.FD = ~s[0];
        @(posedge C);
        #1;
        fs.START = 1'b0;
        chk("start_fr", fs.FR, 1'b1);
        chk("start_ld", LD, 1'b0);
        chk("start_err", ERR, 1'b0);
        for (int i = 0; i < NS; i++) begin
            if (i == gap_at) begin
                fs.FV = 1'b0;
                repeat (gap_len) @(posedge C);
                #1;
                chk("gap_fr", fs.FR, 1'b1);
                chk("gap_ld", LD, 1'b0);
            end
            fs.FD = s[i];
            fs.FV = 1'b1;
            @(posedge C);
            #1;
            if (i < NS - 1)
                chk("ld_early", LD, 1'b0);
        end
        fs.FV = 1'b0;
        m_cfg = s;
        m_act = exp_ok;
        chk("ld_final", LD, exp_ok);
        chk("fr_final", fs.FR, 1'b0);
        chk("err_final", ERR, !exp_ok);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0] s;
        fs.START = 1'b0;
        fs.FD = 1'b0;
        fs.FV = 1'b0;
        A = 2'b11;
        E = 1'b1;

        // Reset
        repeat (2) @(posedge C);
        #1;
        chk("rst_fr", fs.FR, 1'b0);
        chk("rst_ld", LD, 1'b0);
        chk("rst_y", Y, 1'b0);
        chk("rst_yoe", YOE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        R = 1'b0;

        // Combinational load: term0 = A0&A1, term1 never matches
        load(mk(8'h3A, 1'b0, 1'b0), -1, 0, 1'b1);
        E = 1'b1;
        A = 2'b11;
        #1;
        chk("comb_a11_y", Y, 1'b1);
        chk("comb_a11_yoe", YOE, 1'b1);
        A = 2'b01;
        #1;
        chk("comb_a01_y", Y, 1'b0);
        E = 1'b0;
        #1;
        chk("comb_e0_yoe", YOE, 1'b0);

        // Registered and inverted
        load(mk(8'h3A, 1'b1, 1'b1), -1, 0, 1'b1);
        E = 1'b1;
        A = 2'b01;
        @(posedge C);
        #1;
        chk("reg_a01_y", Y, 1'b1);
        A = 2'b11;
        #1;
        chk("reg_hold_y", Y, 1'b1);
        @(posedge C);
        #1;
        chk("reg_a11_y", Y, 1'b0);
        check_outs("reg_model");

        // Flow control gap after bit 4
        load(mk(NT'($urandom), 1'b0, 1'b1), 4, 3, 1'b1);
        check_outs("gap_model");

        // Restart after 5 bits, then full reload
        fs.START = 1'b1;
        @(posedge C);
        #1;
        fs.START = 1'b0;
        m_act = 0;
        m_q = 0;
        fs.FV = 1'b1;
        repeat (5) begin
            fs.FD = 1'($urandom);
            @(posedge C);
            #1;
        end
        chk("partial_ld", LD, 1'b0);
        load(mk(8'h3A, 1'b0, 1'b0), -1, 0, 1'b1);
        A = 2'b11;
        #1;
        chk("restart_y", Y, 1'b1);

        // Reset mid-load
        fs.START = 1'b1;
        @(posedge C);
        #1;
        fs.START = 1'b0;
        m_act = 0;
        m_q = 0;
        fs.FV = 1'b1;
        repeat (4) begin
            fs.FD = 1'b1;
            @(posedge C);
            #1;
        end
        R = 1'b1;
        @(posedge C);
        #1;
        R = 1'b0;
        chk("rmid_fr", fs.FR, 1'b0);
        chk("rmid_ld", LD, 1'b0);
        chk("rmid_y", Y, 1'b0);
        chk("rmid_yoe", YOE, 1'b0);
        repeat (NS) @(posedge C);
        #1;
        fs.FV = 1'b0;
        chk("rmid_noload_ld", LD, 1'b0);
        chk("rmid_noload_fr", fs.FR, 1'b0);

`ifdef GAL_FUSE_PARITY_EN
        // Bad parity, then recovery
        s = mk(8'h3A, 1'b0, 1'b0);
        s[N] = ~s[N];
        load(s, -1, 0, 1'b0);
        E = 1'b1;
        #1;
        chk("par_err", ERR, 1'b1);
        chk("par_ld", LD, 1'b0);
        chk("par_yoe", YOE, 1'b0);
        load(mk(8'h3A, 1'b0, 1'b0), -1, 0, 1'b1);
`endif

        // Randomized configurations and inputs
        repeat (10) begin
            s = mk(NT'($urandom), 1'($urandom), 1'($urandom));
            load(s, int'($urandom_range(0, NS - 1)),
                 int'($urandom_range(0, 3)), 1'b1);
            repeat (16) begin
                A = W'($urandom);
                E = 1'($urandom);
                #1;
                check_outs("rnd_pre");
                @(posedge C);
                #1;
                check_outs("rnd_post");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
